// File: rtl/jpeg_rd_pkg.sv
// Shared definitions for the JPEG entropy-segment bit reader.
package jpeg_rd_pkg;

  localparam int BUF_W_DEF = 32;
  localparam int WIN_W_DEF = 16;

  localparam logic [7:0] JPEG_FF    = 8'hFF;
  localparam logic [7:0] JPEG_STUFF = 8'h00;
  localparam logic [7:0] JPEG_RST0  = 8'hD0;
  localparam logic [7:0] JPEG_RST1  = 8'hD1;
  localparam logic [7:0] JPEG_RST2  = 8'hD2;
  localparam logic [7:0] JPEG_RST3  = 8'hD3;
  localparam logic [7:0] JPEG_RST4  = 8'hD4;
  localparam logic [7:0] JPEG_RST5  = 8'hD5;
  localparam logic [7:0] JPEG_RST6  = 8'hD6;
  localparam logic [7:0] JPEG_RST7  = 8'hD7;
  localparam logic [7:0] JPEG_EOI   = 8'hD9;

  // Byte-parsing state: plain data, just saw 0xFF, or parked on a marker.
  typedef enum logic [1:0] {
    S_DATA   = 2'd0,
    S_FF     = 2'd1,
    S_MARKER = 2'd2
  } rd_state_e;

endpackage

// File: rtl/jpeg_bit_buffer.sv
// MSB-aligned bit buffer: drops consumed bits from the top and appends a
// byte directly below the surviving bits. Bits below the count are always 0,
// so the window reads 0 past the valid data without extra masking.
module jpeg_bit_buffer #(
  parameter  int BUF_W = 32,
  parameter  int WIN_W = 16,
  localparam int CNT_W = $clog2(BUF_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             append_en,
  input  logic [7:0]       append_byte,
  input  logic [4:0]       consume_len,
  output logic [WIN_W-1:0] window,
  output logic [CNT_W-1:0] count
);

  logic [BUF_W-1:0] bits_q, bits_d, kept, placed;
  logic [CNT_W-1:0] count_q, count_d, remain;

  // Shift out consumed bits, then drop the new byte just below what remains.
  always_comb begin
    kept    = bits_q << consume_len;
    remain  = count_q - CNT_W'(consume_len);
    placed  = {append_byte, {(BUF_W-8){1'b0}}} >> remain;
    bits_d  = kept;
    count_d = remain;
    if (clear) begin
      bits_d  = '0;
      count_d = '0;
    end else if (append_en) begin
      bits_d  = kept | placed;
      count_d = remain + CNT_W'(8);
    end
  end

  // Buffer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q  <= '0;
      count_q <= '0;
    end else begin
      bits_q  <= bits_d;
      count_q <= count_d;
    end
  end

  assign window = bits_q[BUF_W-1 -: WIN_W];
  assign count  = count_q;

endmodule

// File: rtl/jpeg_bitstream_reader.sv
// JPEG entropy-segment reader: unstuffs 0xFF00, parks on markers until
// acknowledged, and exposes an MSB-first peek window to the Huffman decoder.
module jpeg_bitstream_reader
  import jpeg_rd_pkg::*;
#(
  parameter  int BUF_W = BUF_W_DEF,
  parameter  int WIN_W = WIN_W_DEF,
  localparam int CNT_W = $clog2(BUF_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIN_W-1:0] bits_window,
  output logic [CNT_W-1:0] bits_count,
  input  logic             consume_valid,
  input  logic [4:0]       consume_len,
  output logic             consume_ready,
  output logic             marker_valid,
  output logic [7:0]       marker_code,
  input  logic             marker_ack,
  output logic             err_overconsume
);

  rd_state_e  state_q, state_d;
  logic       marker_valid_q, marker_valid_d;
  logic [7:0] marker_code_q, marker_code_d;
  logic       err_q, err_d;
  logic       accept, append_en, clear;
  logic [7:0] append_byte;
  logic [4:0] eff_len;

  // Handshakes depend only on registered state and the requested length.
  always_comb begin
    in_ready      = (state_q != S_MARKER) && (bits_count <= CNT_W'(BUF_W - 8));
    consume_ready = (int'(consume_len) <= WIN_W) && (int'(consume_len) <= int'(bits_count));
    accept        = in_valid && in_ready;
    eff_len       = (consume_valid && consume_ready) ? consume_len : 5'd0;
  end

  // Byte parser: unstuffing, fill-byte skipping, marker capture and release.
  always_comb begin
    state_d        = state_q;
    marker_valid_d = marker_valid_q;
    marker_code_d  = marker_code_q;
    append_en      = 1'b0;
    append_byte    = in_data;
    clear          = 1'b0;
    case (state_q)
      S_DATA: begin
        if (accept) begin
          if (in_data == JPEG_FF) state_d = S_FF;
          else                    append_en = 1'b1;
        end
      end
      S_FF: begin
        if (accept) begin
          if (in_data == JPEG_STUFF) begin
            append_en   = 1'b1;
            append_byte = JPEG_FF;
            state_d     = S_DATA;
          end else if (in_data != JPEG_FF) begin
            marker_code_d  = in_data;
            marker_valid_d = 1'b1;
            state_d        = S_MARKER;
          end
        end
      end
      S_MARKER: begin
        if (marker_ack) begin
          marker_valid_d = 1'b0;
          clear          = 1'b1;
          state_d        = S_DATA;
        end
      end
      default: state_d = S_DATA;
    endcase
  end

  // Over-length consume requests latch an error until reset.
  always_comb begin
    err_d = err_q | (consume_valid && (int'(consume_len) > WIN_W));
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_DATA;
      marker_valid_q <= 1'b0;
      marker_code_q  <= 8'h00;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      marker_valid_q <= marker_valid_d;
      marker_code_q  <= marker_code_d;
      err_q          <= err_d;
    end
  end

  jpeg_bit_buffer #(.BUF_W(BUF_W), .WIN_W(WIN_W)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .append_en   (append_en),
    .append_byte (append_byte),
    .consume_len (eff_len),
    .window      (bits_window),
    .count       (bits_count)
  );

  assign marker_valid    = marker_valid_q;
  assign marker_code     = marker_code_q;
  assign err_overconsume = err_q;

endmodule

// File: tb/tb_jpeg_bitstream_reader.sv
// Bench for jpeg_bitstream_reader: directed scenarios plus a randomized run
// against a bit-queue reference model.
module tb_jpeg_bitstream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] bits_window;
  logic [5:0]  bits_count;
  logic        consume_valid = 1'b0;
  logic [4:0]  consume_len = 5'd0;
  logic        consume_ready;
  logic        marker_valid;
  logic [7:0]  marker_code;
  logic        marker_ack = 1'b0;
  logic        err_overconsume;

  int errors = 0;
  int checks = 0;

  // Reference model: the buffer is a queue of bits, oldest first.
  bit       mq[$];
  int       mstate;
  bit       mmv;
  bit [7:0] mcode;
  bit       merr;

  logic seen_in_ready, seen_c_ready, exp_in_ready, exp_c_ready;

  jpeg_bitstream_reader dut (
    .clk             (clk),
    .rst             (rst),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .bits_window     (bits_window),
    .bits_count      (bits_count),
    .consume_valid   (consume_valid),
    .consume_len     (consume_len),
    .consume_ready   (consume_ready),
    .marker_valid    (marker_valid),
    .marker_code     (marker_code),
    .marker_ack      (marker_ack),
    .err_overconsume (err_overconsume)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    mq.delete();
    mstate = 0;
    mmv    = 0;
    mcode  = 8'h00;
    merr   = 0;
  endtask

  function automatic logic [15:0] model_window();
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++) if (i < mq.size()) w[15-i] = mq[i];
    return w;
  endfunction

  task automatic push_byte(input bit [7:0] b);
    for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
  endtask

  // Advance the model by one clock given the inputs present before the edge.
  task automatic model_update(input logic iv, input logic [7:0] id, input logic cv,
                              input logic [4:0] cl, input logic ack);
    if (cv && cl > 16) merr = 1;
    if (cv && exp_c_ready) repeat (cl) void'(mq.pop_front());
    if (mstate == 2) begin
      if (ack) begin
        mq.delete();
        mmv    = 0;
        mstate = 0;
      end
    end else if (iv && exp_in_ready) begin
      if (mstate == 0) begin
        if (id == 8'hFF) mstate = 1;
        else push_byte(id);
      end else begin
        if (id == 8'h00) begin
          push_byte(8'hFF);
          mstate = 0;
        end else if (id != 8'hFF) begin
          mcode  = id;
          mmv    = 1;
          mstate = 2;
        end
      end
    end
  endtask

  // One clock of stimulus; captures the DUT and model handshakes before the edge.
  task automatic cycle(input logic iv, input logic [7:0] id, input logic cv,
                       input logic [4:0] cl, input logic ack);
    in_valid      = iv;
    in_data       = id;
    consume_valid = cv;
    consume_len   = cl;
    marker_ack    = ack;
    #1;
    seen_in_ready = in_ready;
    seen_c_ready  = consume_ready;
    exp_in_ready  = (mstate != 2) && (mq.size() <= 24);
    exp_c_ready   = (cl <= 16) && (int'(cl) <= mq.size());
    @(posedge clk);
    model_update(iv, id, cv, cl, ack);
    #1;
    in_valid      = 1'b0;
    consume_valid = 1'b0;
    marker_ack    = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    rst           = 1'b1;
    in_valid      = 1'b0;
    consume_valid = 1'b0;
    marker_ack    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset(2);
    checks++; if (bits_count !== 6'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bits_count); end
    checks++; if (marker_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mv: got %0b expected 0", marker_valid); end
    checks++; if (marker_code !== 8'h00) begin errors++; $display("[TB] FAIL reset_code: got %0h expected 00", marker_code); end
    checks++; if (err_overconsume !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %0b expected 0", err_overconsume); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
    checks++; if (bits_window !== 16'h0000) begin errors++; $display("[TB] FAIL reset_window: got %0h expected 0000", bits_window); end
  endtask

  task automatic test_basic();
    logic [3:0] nib [4] = '{4'hA, 4'h5, 4'h3, 4'hC};
    cycle(1, 8'hA5, 0, 0, 0);
    cycle(1, 8'h3C, 0, 0, 0);
    checks++; if (bits_window !== 16'hA53C) begin errors++; $display("[TB] FAIL basic_window: got %0h expected a53c", bits_window); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bits_window[15:12] !== nib[i]) begin errors++; $display("[TB] FAIL basic_nibble%0d: got %0h expected %0h", i, bits_window[15:12], nib[i]); end
      checks++; if (bits_count !== 6'(16 - 4*i)) begin errors++; $display("[TB] FAIL basic_count%0d: got %0d expected %0d", i, bits_count, 16 - 4*i); end
      cycle(0, 8'h00, 1, 5'd4, 0);
    end
    checks++; if (bits_count !== 6'd0) begin errors++; $display("[TB] FAIL basic_empty: got %0d expected 0", bits_count); end
  endtask

  task automatic test_stuffing();
    cycle(1, 8'hFF, 0, 0, 0);
    cycle(1, 8'h00, 0, 0, 0);
    cycle(1, 8'h12, 0, 0, 0);
    checks++; if (bits_count !== 6'd16) begin errors++; $display("[TB] FAIL stuff_count: got %0d expected 16", bits_count); end
    checks++; if (bits_window !== 16'hFF12) begin errors++; $display("[TB] FAIL stuff_window: got %0h expected ff12", bits_window); end
    checks++; if (marker_valid !== 1'b0) begin errors++; $display("[TB] FAIL stuff_mv: got %0b expected 0", marker_valid); end
    cycle(0, 8'h00, 1, 5'd16, 0);
    checks++; if (bits_count !== 6'd0) begin errors++; $display("[TB] FAIL stuff_drain: got %0d expected 0", bits_count); end
  endtask

  task automatic test_marker();
    cycle(1, 8'hAB, 0, 0, 0);
    cycle(1, 8'hFF, 0, 0, 0);
    cycle(1, 8'hFF, 0, 0, 0);
    cycle(1, 8'hD0, 0, 0, 0);
    checks++; if (bits_count !== 6'd8) begin errors++; $display("[TB] FAIL marker_count: got %0d expected 8", bits_count); end
    checks++; if (marker_valid !== 1'b1) begin errors++; $display("[TB] FAIL marker_mv: got %0b expected 1", marker_valid); end
    checks++; if (marker_code !== 8'hD0) begin errors++; $display("[TB] FAIL marker_code: got %0h expected d0", marker_code); end
    cycle(0, 8'h00, 1, 5'd3, 0);
    checks++; if (seen_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL marker_in_ready: got %0b expected 0", seen_in_ready); end
    checks++; if (bits_count !== 6'd5) begin errors++; $display("[TB] FAIL marker_consume: got %0d expected 5", bits_count); end
    cycle(0, 8'h00, 0, 0, 1);
    checks++; if (bits_count !== 6'd0) begin errors++; $display("[TB] FAIL marker_ack_count: got %0d expected 0", bits_count); end
    checks++; if (marker_valid !== 1'b0) begin errors++; $display("[TB] FAIL marker_ack_mv: got %0b expected 0", marker_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL marker_ack_ready: got %0b expected 1", in_ready); end
    cycle(1, 8'h55, 0, 0, 0);
    checks++; if (bits_window !== 16'h5500) begin errors++; $display("[TB] FAIL marker_next_window: got %0h expected 5500", bits_window); end
    cycle(0, 8'h00, 1, 5'd8, 0);
  endtask

  task automatic test_back_to_back();
    cycle(1, 8'h11, 0, 0, 0);
    cycle(1, 8'h22, 0, 0, 0);
    cycle(1, 8'h33, 0, 0, 0);
    cycle(1, 8'h44, 0, 0, 0);
    checks++; if (bits_count !== 6'd32) begin errors++; $display("[TB] FAIL full_count: got %0d expected 32", bits_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready: got %0b expected 0", in_ready); end
    cycle(1, 8'h55, 1, 5'd8, 0);
    checks++; if (seen_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_held: got %0b expected 0", seen_in_ready); end
    checks++; if (bits_count !== 6'd24) begin errors++; $display("[TB] FAIL full_after_consume: got %0d expected 24", bits_count); end
    cycle(1, 8'h55, 1, 5'd8, 0);
    checks++; if (seen_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready: got %0b expected 1", seen_in_ready); end
    checks++; if (bits_count !== 6'd24) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 24", bits_count); end
    checks++; if (bits_window !== 16'h3344) begin errors++; $display("[TB] FAIL b2b_window: got %0h expected 3344", bits_window); end
    cycle(0, 8'h00, 1, 5'd16, 0);
    cycle(0, 8'h00, 1, 5'd8, 0);
    checks++; if (bits_count !== 6'd0) begin errors++; $display("[TB] FAIL b2b_drain: got %0d expected 0", bits_count); end
  endtask

  task automatic test_overconsume();
    cycle(1, 8'hE0, 0, 0, 0);
    cycle(0, 8'h00, 1, 5'd3, 0);
    cycle(0, 8'h00, 1, 5'd6, 0);
    checks++; if (seen_c_ready !== 1'b0) begin errors++; $display("[TB] FAIL short_ready: got %0b expected 0", seen_c_ready); end
    checks++; if (bits_count !== 6'd5) begin errors++; $display("[TB] FAIL short_count: got %0d expected 5", bits_count); end
    checks++; if (err_overconsume !== 1'b0) begin errors++; $display("[TB] FAIL short_err: got %0b expected 0", err_overconsume); end
    cycle(0, 8'h00, 1, 5'd17, 0);
    checks++; if (seen_c_ready !== 1'b0) begin errors++; $display("[TB] FAIL over_ready: got %0b expected 0", seen_c_ready); end
    checks++; if (err_overconsume !== 1'b1) begin errors++; $display("[TB] FAIL over_err: got %0b expected 1", err_overconsume); end
    checks++; if (bits_count !== 6'd5) begin errors++; $display("[TB] FAIL over_count: got %0d expected 5", bits_count); end
    cycle(1, 8'h12, 0, 0, 0);
    cycle(0, 8'h00, 1, 5'd13, 0);
    checks++; if (bits_count !== 6'd0) begin errors++; $display("[TB] FAIL over_drain: got %0d expected 0", bits_count); end
    checks++; if (err_overconsume !== 1'b1) begin errors++; $display("[TB] FAIL over_sticky: got %0b expected 1", err_overconsume); end
  endtask

  task automatic test_reset_in_marker();
    cycle(1, 8'hAB, 0, 0, 0);
    cycle(1, 8'hCD, 0, 0, 0);
    cycle(0, 8'h00, 1, 5'd4, 0);
    cycle(1, 8'hFF, 0, 0, 0);
    cycle(1, 8'hD9, 0, 0, 0);
    checks++; if (marker_code !== 8'hD9 || bits_count !== 6'd12) begin errors++; $display("[TB] FAIL eoi_setup: got code %0h count %0d expected d9 12", marker_code, bits_count); end
    apply_reset(1);
    checks++; if (marker_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstm_mv: got %0b expected 0", marker_valid); end
    checks++; if (marker_code !== 8'h00) begin errors++; $display("[TB] FAIL rstm_code: got %0h expected 00", marker_code); end
    checks++; if (bits_count !== 6'd0) begin errors++; $display("[TB] FAIL rstm_count: got %0d expected 0", bits_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstm_in_ready: got %0b expected 1", in_ready); end
    checks++; if (err_overconsume !== 1'b0) begin errors++; $display("[TB] FAIL rstm_err: got %0b expected 0", err_overconsume); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [4:0] cl;
    int         r;
    apply_reset(2);
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      b = 8'hFF;
      else if (r == 3) b = 8'h00;
      else if (r == 4) b = ($urandom_range(0, 8) == 8) ? 8'hD9 : 8'(8'hD0 + $urandom_range(0, 7));
      else             b = 8'($urandom);
      cl = ($urandom_range(0, 24) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
      cycle(logic'($urandom_range(0, 9) < 7), b, logic'($urandom_range(0, 9) < 6), cl,
            logic'($urandom_range(0, 3) == 0));
      checks++; if (seen_in_ready !== exp_in_ready) begin errors++; $display("[TB] FAIL rnd_in_ready@%0d: got %0b expected %0b", n, seen_in_ready, exp_in_ready); end
      checks++; if (seen_c_ready !== exp_c_ready) begin errors++; $display("[TB] FAIL rnd_c_ready@%0d: got %0b expected %0b", n, seen_c_ready, exp_c_ready); end
      checks++; if (bits_count !== 6'(mq.size())) begin errors++; $display("[TB] FAIL rnd_count@%0d: got %0d expected %0d", n, bits_count, mq.size()); end
      checks++; if (bits_window !== model_window()) begin errors++; $display("[TB] FAIL rnd_window@%0d: got %0h expected %0h", n, bits_window, model_window()); end
      checks++; if (marker_valid !== mmv || marker_code !== mcode) begin errors++; $display("[TB] FAIL rnd_marker@%0d: got %0b/%0h expected %0b/%0h", n, marker_valid, marker_code, mmv, mcode); end
      checks++; if (err_overconsume !== merr) begin errors++; $display("[TB] FAIL rnd_err@%0d: got %0b expected %0b", n, err_overconsume, merr); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_stuffing();
    test_marker();
    test_back_to_back();
    test_overconsume();
    test_reset_in_marker();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jpeg_bitstream_reader.md
Name: jpeg_bitstream_reader

Overview:
- Bit-level reader for the JPEG entropy-coded segment. It is the decode-side counterpart of the entropy/bitstream writer.
- Accepts a byte stream over a valid/ready handshake and removes stuffed 0x00 bytes that follow 0xFF.
- Detects markers and pauses on them until software/FSM acknowledges.
- Presents a 16-bit MSB-first peek window that a downstream Huffman decoder consumes 0..16 bits at a time.

Parameters:
- BUF_W, 32, bit-buffer depth in bits; must be >= 24 and a multiple of 8.
- WIN_W, 16, peek window width; maximum bits consumable per cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  input byte.
- in_valid  in  1  input byte valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- bits_window  out  WIN_W  next WIN_W bits, MSB = oldest bit; bits beyond bits_count read 0.
- bits_count  out  clog2(BUF_W)+1  valid bits in buffer, 0..BUF_W.
- consume_valid  in  1  request to drop consume_len bits.
- consume_len  in  5  bits to drop, 0..WIN_W.
- consume_ready  out  1  request honoured this cycle.
- marker_valid  out  1  marker held.
- marker_code  out  8  second byte of held marker.
- marker_ack  in  1  releases held marker.
- err_overconsume  out  1  sticky; set on consume_valid with consume_len > WIN_W.

Behaviour:
- Reset: state S_DATA, buffer 0, bits_count 0, marker_valid 0, marker_code 0x00, err_overconsume 0. in_ready is therefore 1 in the first cycle after reset.
- in_ready = (state != S_MARKER) && (bits_count <= BUF_W-8). It is computed from registered state only, with no dependence on a same-cycle consume.
- consume_ready = consume_len <= bits_count && consume_len <= WIN_W. It is purely combinational from the current count.
- consume_len = 0 is a no-op with ready = 1.
- consume_len > WIN_W gives ready = 0 and sets err_overconsume (cleared only by rst).
- consume_len > bits_count gives ready = 0; the bench retries.
- FSM S_DATA, accepted byte:
  - != 0xFF: append 8 bits, stay.
  - == 0xFF: append nothing, go to S_FF.
- FSM S_FF, accepted byte:
  - 0x00: append 0xFF, go to S_DATA.
  - 0xFF: fill byte, append nothing, stay in S_FF.
  - other: marker_code <= byte, marker_valid <= 1, go to S_MARKER.
- FSM S_MARKER:
  - No input accepted.
  - Consumption of remaining buffered bits is still allowed.
  - On marker_ack: marker_valid <= 0, discard all remaining buffered bits (bits_count <= 0), go to S_DATA. This discards the pad-to-byte 1-bits before RSTn/EOI.
  - marker_ack outside S_MARKER is ignored.
- Simultaneous append and consume in one cycle:
  - new buffer = (buf << k) with the byte placed at bit offset BUF_W - (count - k) - 8, MSB-aligned.
  - new count = count - k + 8.
  - The appended byte is visible in bits_window the cycle after acceptance (latency 1). A consumed bit is gone the next cycle.
- bits_count never exceeds BUF_W. With BUF_W=32, at most 4 bytes are ever buffered.
- Mid-operation rst overrides everything, including a held marker and partial 0xFF state.

Decomposition:
- Shared package jpeg_rd_pkg holds:
  - state enum {S_DATA, S_FF, S_MARKER}.
  - constants JPEG_FF=8'hFF, JPEG_STUFF=8'h00, JPEG_RST0..RST7=8'hD0..D7, JPEG_EOI=8'hD9.
  - WIN_W default.
- One natural sub-module, jpeg_bit_buffer: shift/append datapath (buffer, count, window extraction) with append_en/append_byte/consume_len inputs.
- The top level holds the FSM, handshakes and error flag.

Test Plan:
- After rst, drive bytes 0xA5, 0x3C, then consume 4 four times -> bits_window top nibbles A, 5, 3, C in successive cycles; bits_count 16 -> 12 -> 8 -> 4 -> 0.
- Drive 0xFF, 0x00, 0x12 -> bits_count 16, bits_window = 0xFF12, marker_valid stays 0.
- Drive 0xAB, 0xFF, 0xFF, 0xD0 -> bits_count 8, marker_valid = 1, marker_code = 0xD0, in_ready = 0. Consume 3 -> count 5. marker_ack -> count 0, in_ready = 1, next byte 0x55 yields window 0x5500.
- Feed 4 bytes without consuming -> in_ready drops at bits_count 32. A 5th in_valid is held off until consume 8; then with count 24, a same-cycle consume 8 + append gives count 24 the next cycle.
- With bits_count 5, consume_valid with consume_len 6 -> consume_ready 0, no state change. consume_len 17 -> consume_ready 0, err_overconsume 1 and remaining 1 after later traffic.
- Assert rst while in S_MARKER holding 0xD9 with count 12 -> next cycle marker_valid 0, marker_code 0x00, bits_count 0, in_ready 1.
